// File: rtl/cache_retire_ctrl.sv
// cache_retire_ctrl: per-entry cache line lifecycle controller.
// Each entry walks INVALID -> VALID -> RETIRING -> INVALID, driving the
// downstream checker's valid (cache) and retire flags from registered state.
//
// state       | meaning
// ------------+----------------------------------------------------------
// ST_INVALID  | line free; only an allocate is accepted
// ST_VALID    | line allocated; only a retire is accepted
// ST_RETIRING | retire in progress; timer counts down to the valid clear
module cache_retire_ctrl #(
    parameter int N_ENTRIES  = 3,
    parameter int ADDR_W     = 2,
    parameter int RETIRE_LAT = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 alloc_req,
    input  logic [ADDR_W-1:0]    alloc_addr,
    input  logic                 retire_req,
    input  logic [ADDR_W-1:0]    retire_addr,
    output logic [N_ENTRIES-1:0] cache,
    output logic [N_ENTRIES-1:0] retire,
    output logic                 alloc_ack,
    output logic                 alloc_err,
    output logic                 retire_err,
    output logic [ADDR_W:0]      free_cnt,
    output logic                 full
);

    // Encoding keeps bit 0 as "valid" and bit 1 as "retiring".
    typedef enum logic [1:0] {
        ST_INVALID  = 2'b00,
        ST_VALID    = 2'b01,
        ST_RETIRING = 2'b11
    } state_e;

    state_e     state_q [N_ENTRIES];
    state_e     state_d [N_ENTRIES];
    logic [3:0] timer_q [N_ENTRIES];
    logic [3:0] timer_d [N_ENTRIES];

    logic alloc_hit;
    logic retire_hit;
    logic alloc_ack_q,  alloc_ack_d;
    logic alloc_err_q,  alloc_err_d;
    logic retire_err_q, retire_err_d;

    // Per-entry next state; a request that matches no entry in the right
    // state (including out-of-range addresses) becomes an error pulse.
    always_comb begin
        alloc_hit  = 1'b0;
        retire_hit = 1'b0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            state_d[i] = state_q[i];
            timer_d[i] = timer_q[i];
            case (state_q[i])
                ST_INVALID: begin
                    if (alloc_req && (alloc_addr == ADDR_W'(i))) begin
                        state_d[i] = ST_VALID;
                        alloc_hit  = 1'b1;
                    end
                end
                ST_VALID: begin
                    if (retire_req && (retire_addr == ADDR_W'(i))) begin
                        state_d[i] = ST_RETIRING;
                        timer_d[i] = 4'(RETIRE_LAT - 1);
                        retire_hit = 1'b1;
                    end
                end
                ST_RETIRING: begin
                    if (timer_q[i] != 4'd0) begin
                        timer_d[i] = timer_q[i] - 4'd1;
                    end else begin
                        state_d[i] = ST_INVALID;
                    end
                end
                default: begin
                    state_d[i] = ST_INVALID;
                    timer_d[i] = 4'd0;
                end
            endcase
        end
        alloc_ack_d  = alloc_hit;
        alloc_err_d  = alloc_req  & ~alloc_hit;
        retire_err_d = retire_req & ~retire_hit;
    end

    // State, timers and response pulses; reset aborts any retire in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                state_q[i] <= ST_INVALID;
                timer_q[i] <= 4'd0;
            end
            alloc_ack_q  <= 1'b0;
            alloc_err_q  <= 1'b0;
            retire_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
            end
            alloc_ack_q  <= alloc_ack_d;
            alloc_err_q  <= alloc_err_d;
            retire_err_q <= retire_err_d;
        end
    end

    // Flags and free count decoded purely from the state registers.
    always_comb begin
        free_cnt = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            cache[i]  = (state_q[i] != ST_INVALID);
            retire[i] = (state_q[i] == ST_RETIRING);
            if (state_q[i] == ST_INVALID) begin
                free_cnt = free_cnt + (ADDR_W+1)'(1);
            end
        end
        full = (free_cnt == '0);
    end

    assign alloc_ack  = alloc_ack_q;
    assign alloc_err  = alloc_err_q;
    assign retire_err = retire_err_q;

endmodule

// File: tb/tb_cache_retire_ctrl.sv
// Directed bench for cache_retire_ctrl with the default parameters
// (3 entries, 2-bit index, RETIRE_LAT = 3).
module tb_cache_retire_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       alloc_req;
    logic [1:0] alloc_addr;
    logic       retire_req;
    logic [1:0] retire_addr;
    logic [2:0] cache;
    logic [2:0] retire;
    logic       alloc_ack;
    logic       alloc_err;
    logic       retire_err;
    logic [2:0] free_cnt;
    logic       full;

    int checks   = 0;
    int failures = 0;

    cache_retire_ctrl #(
        .N_ENTRIES (3),
        .ADDR_W    (2),
        .RETIRE_LAT(3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .alloc_req  (alloc_req),
        .alloc_addr (alloc_addr),
        .retire_req (retire_req),
        .retire_addr(retire_addr),
        .cache      (cache),
        .retire     (retire),
        .alloc_ack  (alloc_ack),
        .alloc_err  (alloc_err),
        .retire_err (retire_err),
        .free_cnt   (free_cnt),
        .full       (full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic ar, input logic [1:0] aa, input logic rr, input logic [1:0] ra);
        alloc_req   = ar;
        alloc_addr  = aa;
        retire_req  = rr;
        retire_addr = ra;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [2:0] c, input logic [2:0] r,
                             input logic ack, input logic aerr, input logic rerr,
                             input logic [2:0] fc, input logic fl);
        check({tag, ".cache"},      32'(cache),      32'(c));
        check({tag, ".retire"},     32'(retire),     32'(r));
        check({tag, ".alloc_ack"},  32'(alloc_ack),  32'(ack));
        check({tag, ".alloc_err"},  32'(alloc_err),  32'(aerr));
        check({tag, ".retire_err"}, 32'(retire_err), 32'(rerr));
        check({tag, ".free_cnt"},   32'(free_cnt),   32'(fc));
        check({tag, ".full"},       32'(full),       32'(fl));
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 2'd0, 1'b0, 2'd0);
        #12;
        check_all("reset", 3'b000, 3'b000, 0, 0, 0, 3'd3, 0);
        reset = 1'b0;

        // allocate entry 2
        drive(1'b1, 2'd2, 1'b0, 2'd0);
        step();
        drive(1'b0, 2'd0, 1'b0, 2'd0);
        check_all("alloc2", 3'b100, 3'b000, 1, 0, 0, 3'd2, 0);
        step();
        check_all("alloc2_idle", 3'b100, 3'b000, 0, 0, 0, 3'd2, 0);

        // retire entry 2; flags fall three edges later
        drive(1'b0, 2'd0, 1'b1, 2'd2);
        step();
        drive(1'b0, 2'd0, 1'b0, 2'd0);
        check_all("ret2_k", 3'b100, 3'b100, 0, 0, 0, 3'd2, 0);
        step();
        check_all("ret2_k1", 3'b100, 3'b100, 0, 0, 0, 3'd2, 0);
        step();
        check_all("ret2_k2", 3'b100, 3'b100, 0, 0, 0, 3'd2, 0);
        // alloc during the final retiring cycle is rejected, retry succeeds
        drive(1'b1, 2'd2, 1'b0, 2'd0);
        step();
        check_all("ret2_k3", 3'b000, 3'b000, 0, 1, 0, 3'd3, 0);
        step();
        drive(1'b0, 2'd0, 1'b0, 2'd0);
        check_all("realloc2", 3'b100, 3'b000, 1, 0, 0, 3'd2, 0);

        // retire an INVALID entry, allocate an out-of-range index
        drive(1'b0, 2'd0, 1'b1, 2'd1);
        step();
        check_all("ret1_inv", 3'b100, 3'b000, 0, 0, 1, 3'd2, 0);
        drive(1'b1, 2'd3, 1'b0, 2'd0);
        step();
        drive(1'b0, 2'd0, 1'b0, 2'd0);
        check_all("alloc3", 3'b100, 3'b000, 0, 1, 0, 3'd2, 0);

        // fill up, then one extra alloc
        drive(1'b1, 2'd0, 1'b0, 2'd0);
        step();
        check_all("alloc0", 3'b101, 3'b000, 1, 0, 0, 3'd1, 0);
        drive(1'b1, 2'd1, 1'b0, 2'd0);
        step();
        check_all("alloc1_full", 3'b111, 3'b000, 1, 0, 0, 3'd0, 1);
        step();
        drive(1'b0, 2'd0, 1'b0, 2'd0);
        check_all("alloc1_again", 3'b111, 3'b000, 0, 1, 0, 3'd0, 1);

        // same-entry alloc + retire on a VALID entry
        drive(1'b1, 2'd1, 1'b1, 2'd1);
        step();
        drive(1'b0, 2'd0, 1'b0, 2'd0);
        check_all("same_valid", 3'b111, 3'b010, 0, 1, 0, 3'd0, 1);
        step();
        step();
        check_all("ret1_k2", 3'b111, 3'b010, 0, 0, 0, 3'd0, 1);
        step();
        check_all("ret1_k3", 3'b101, 3'b000, 0, 0, 0, 3'd1, 0);

        // alloc and retire to different entries in one cycle
        drive(1'b1, 2'd1, 1'b1, 2'd0);
        step();
        drive(1'b0, 2'd0, 1'b0, 2'd0);
        check_all("diff_entries", 3'b111, 3'b001, 1, 0, 0, 3'd0, 1);
        step();
        step();
        step();
        check_all("ret0_done", 3'b110, 3'b000, 0, 0, 0, 3'd1, 0);

        // same-entry alloc + retire on an INVALID entry
        drive(1'b1, 2'd0, 1'b1, 2'd0);
        step();
        drive(1'b0, 2'd0, 1'b0, 2'd0);
        check_all("same_invalid", 3'b111, 3'b000, 1, 0, 1, 3'd0, 1);

        // reset in the middle of a retire
        drive(1'b0, 2'd0, 1'b1, 2'd2);
        step();
        drive(1'b0, 2'd0, 1'b0, 2'd0);
        check_all("ret2b_k", 3'b111, 3'b100, 0, 0, 0, 3'd0, 1);
        step();
        check_all("ret2b_k1", 3'b111, 3'b100, 0, 0, 0, 3'd0, 1);
        #2;
        reset = 1'b1;
        #1;
        check_all("mid_reset", 3'b000, 3'b000, 0, 0, 0, 3'd3, 0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_all("post_reset", 3'b000, 3'b000, 0, 0, 0, 3'd3, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
